// File: rtl/maxnet_result_reader.sv
// rtl/maxnet_result_reader.sv - snapshots the Maxnet activation bank and streams it with a winner summary.
// Optional build macro SKIP_NONPOSITIVE_EN: entries <= 0 are skipped instead of offered.
module maxnet_result_reader #(
    parameter int N_UNITS = 4,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = $clog2(N_UNITS),
    parameter int CNT_W   = $clog2(N_UNITS + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N_UNITS*DATA_W-1:0] reg_values,
    output logic                      busy,
    output logic [DATA_W-1:0]         out_data,
    output logic [IDX_W-1:0]          out_index,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      done,
    output logic [CNT_W-1:0]          positive_count,
    output logic                      winner_found,
    output logic [IDX_W-1:0]          winner_index
);

`ifdef SKIP_NONPOSITIVE_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shadow_q [N_UNITS];
    logic [DATA_W-1:0]  shadow_d [N_UNITS];
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               found_q, found_d;
    logic [IDX_W-1:0]   win_q, win_d;

    logic [DATA_W-1:0]  cur;
    logic               cur_pos;
    logic               offer;
    logic               step;
    logic               last;

    assign cur     = shadow_q[idx_q];
    assign cur_pos = ~cur[DATA_W-1] & (|cur);
    assign offer   = (state_q == ST_SCAN) && (!SKIP_EN || cur_pos);
    // A skipped entry advances without waiting for the consumer.
    assign step    = (state_q == ST_SCAN) && (offer ? out_ready : 1'b1);
    assign last    = (idx_q == IDX_W'(N_UNITS - 1));

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        found_d  = found_q;
        win_d    = win_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int i = 0; i < N_UNITS; i++) begin
                        shadow_d[i] = reg_values[i*DATA_W +: DATA_W];
                    end
                    idx_d   = '0;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    win_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (step) begin
                    if (cur_pos) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == '0) begin
                            win_d = idx_q;
                        end
                    end
                    if (last) begin
                        // Results are final as DONE is entered so they are visible alongside done.
                        found_d = (cnt_d == CNT_W'(1));
                        if (!found_d) begin
                            win_d = '0;
                        end
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < N_UNITS; i++) begin
                shadow_q[i] <= '0;
            end
            idx_q   <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            win_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            found_q  <= found_d;
            win_q    <= win_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign out_valid      = offer;
    assign out_data       = cur;
    assign out_index      = idx_q;
    assign positive_count = cnt_q;
    assign winner_found   = found_q;
    assign winner_index   = win_q;

endmodule

// File: tb/tb_maxnet_result_reader.sv
// tb/tb_maxnet_result_reader.sv - randomized self-checking bench for maxnet_result_reader.
module tb_maxnet_result_reader;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

`ifdef SKIP_NONPOSITIVE_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [N*DW-1:0] reg_values;
    logic            busy;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_index;
    logic            out_valid;
    logic            out_ready;
    logic            done;
    logic [CW-1:0]   positive_count;
    logic            winner_found;
    logic [IW-1:0]   winner_index;

    int n_checks = 0;
    int n_pass   = 0;

    maxnet_result_reader #(.N_UNITS(N), .DATA_W(DW)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .reg_values     (reg_values),
        .busy           (busy),
        .out_data       (out_data),
        .out_index      (out_index),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .done           (done),
        .positive_count (positive_count),
        .winner_found   (winner_found),
        .winner_index   (winner_index)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [N*DW-1:0] pack(input logic [DW-1:0] b [N]);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = b[i];
        return r;
    endfunction

    // ready_mode: 0 = always ready, 1 = toggle 1,0,1,0..., 2 = random
    task automatic run_scan(input logic [DW-1:0] bank [N], input int ready_mode, input bit disturb);
        logic [DW-1:0] exp_data [$];
        int            exp_idx [$];
        int            pos_cnt;
        int            win;
        int            cyc;
        int            got;
        bit            done_seen;
        bit            prev_valid, prev_ready;
        logic [DW-1:0] prev_data;
        logic [IW-1:0] prev_idx;

        pos_cnt = 0;
        win = 0;
        for (int i = 0; i < N; i++) begin
            if ($signed(bank[i]) > 0) begin
                if (pos_cnt == 0) win = i;
                pos_cnt++;
            end
            if (!SKIP || $signed(bank[i]) > 0) begin
                exp_data.push_back(bank[i]);
                exp_idx.push_back(i);
            end
        end
        if (pos_cnt != 1) win = 0;

        reg_values = pack(bank);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        got = 0;
        done_seen = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data = '0;
        prev_idx = '0;
        while (!done_seen && cyc < 200) begin
            cyc++;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = cyc[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (disturb && cyc == 2) begin
                start = 1'b1;
                reg_values = ~reg_values;
            end else begin
                start = 1'b0;
            end
            if (prev_valid && !prev_ready) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
                check("hold_index", out_index, prev_idx);
            end
            if (out_valid) check("busy_in_scan", busy, 1);
            if (out_valid && out_ready) begin
                if (got < exp_data.size()) begin
                    check("xfer_data", out_data, exp_data[got]);
                    check("xfer_index", out_index, exp_idx[got]);
                end else begin
                    check("extra_xfer", got, exp_data.size());
                end
                got++;
            end
            if (done) begin
                done_seen = 1'b1;
                check("done_valid", out_valid, 0);
                check("done_busy", busy, 1);
                check("done_count", positive_count, pos_cnt);
                check("done_found", winner_found, pos_cnt == 1);
                check("done_winner", winner_index, win);
                if (ready_mode == 0) check("done_latency", cyc, N + 1);
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data = out_data;
            prev_idx = out_index;
            @(negedge clock);
        end
        start = 1'b0;
        check("done_seen", done_seen, 1);
        check("xfer_count", got, exp_data.size());
        check("done_pulse_end", done, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        repeat (3) @(negedge clock);
        check("no_rescan_busy", busy, 0);
        check("hold_count", positive_count, pos_cnt);
        check("hold_found", winner_found, pos_cnt == 1);
        check("hold_winner", winner_index, win);
    endtask

    function automatic logic [DW-1:0] rand_val();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return DW'($urandom_range(1, 20));
            2: return DW'($urandom) | 32'h8000_0000;
            3: return 32'h8000_0000;
            default: return DW'($urandom) & 32'h7fff_ffff;
        endcase
    endfunction

    initial begin
        logic [DW-1:0] b [N];

        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        reg_values = '0;
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_data", out_data, 0);
        check("rst_index", out_index, 0);
        check("rst_count", positive_count, 0);
        check("rst_found", winner_found, 0);
        check("rst_winner", winner_index, 0);
        reset = 1'b0;
        @(negedge clock);

        b = '{32'd0, 32'd5, 32'd0, 32'd0};
        run_scan(b, 0, 1'b0);
        b = '{32'd3, 32'd7, 32'hFFFF_FFFE, 32'd0};
        run_scan(b, 1, 1'b0);
        b = '{32'd11, 32'hFFFF_FFF0, 32'd0, 32'd4};
        run_scan(b, 0, 1'b1);
        b = '{32'h8000_0000, 32'd0, 32'd0, 32'd1};
        run_scan(b, 0, 1'b0);
        b = '{32'd0, 32'hFFFF_FFFF, 32'd9, 32'd0};
        run_scan(b, 0, 1'b0);
        b = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        run_scan(b, 2, 1'b0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) b[i] = rand_val();
            run_scan(b, t % 3, t[0]);
        end

        // Abort mid-scan: two entries accepted, then reset.
        b = '{32'd2, 32'd6, 32'd8, 32'd1};
        reg_values = pack(b);
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("abort_first_valid", out_valid, 1);
        repeat (2) @(negedge clock);
        check("abort_pre_index", out_index, 2);
        reset = 1'b1;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_count", positive_count, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("abort_no_done", done, 0);
        end
        reset = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        check("abort_idle_done", done, 0);
        run_scan(b, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/maxnet_result_reader.md
Name: maxnet_result_reader

Overview:
Read-side companion to the team's 32-bit load/reset activation registers in the Maxnet datapath. On a start pulse it snapshots the whole register bank and streams every entry out over a valid/ready interface, tagged with its index. While scanning it counts the positive activations and reports the winner. Sits between the Maxnet register bank and the result/host interface.

Parameters:
N_UNITS, 4, number of activation registers read (>=2)
DATA_W, 32, width of each activation; two's-complement signed
IDX_W, $clog2(N_UNITS), width of index outputs
CNT_W, $clog2(N_UNITS+1), width of positive-count output

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to read the bank; honoured only in IDLE
reg_values  input  N_UNITS*DATA_W  packed register outputs; unit i at bits [i*DATA_W +: DATA_W]
busy  output  1  high in SCAN and DONE
out_data  output  DATA_W  activation value being offered
out_index  output  IDX_W  unit index of out_data
out_valid  output  1  out_data/out_index valid
out_ready  input  1  consumer accepts when out_valid && out_ready
done  output  1  one-cycle pulse after the last entry is handled
positive_count  output  CNT_W  number of entries with value > 0 (signed)
winner_found  output  1  1 iff positive_count == 1
winner_index  output  IDX_W  index of the single positive entry; 0 when winner_found=0

Behaviour:
- Reset (async): state IDLE; shadow bank, scan index, out_data, out_index, positive_count, winner_index = 0; out_valid, done, busy, winner_found = 0.
- States: IDLE, SCAN, DONE.
- IDLE: at an edge where start=1: copy reg_values into the shadow bank, clear positive_count/winner_found/winner_index, scan index = 0, go to SCAN. Later reg_values changes are ignored until the next start.
- SCAN: out_valid=1, out_data=shadow[idx], out_index=idx. These are held stable while out_ready=0.
- SCAN handshake: at an edge with out_valid && out_ready, the entry is consumed. positive_count increments if the entry is > 0; the first positive entry's index is latched into winner_index. idx increments.
- The first entry is offered in the cycle after the start edge (1-cycle latency). With out_ready held at 1 there is one entry per cycle.
- SCAN exit: consuming idx == N_UNITS-1 moves to DONE. There is no wrap; idx never exceeds N_UNITS-1.
- DONE: lasts exactly one cycle with done=1 and out_valid=0. winner_found = (positive_count==1), and winner_index is forced to 0 if not found. Then return to IDLE.
- Results (positive_count, winner_found, winner_index) hold from DONE until the next accepted start.
- start while busy is ignored; no queueing. start in the same cycle as done is ignored; the state is DONE, not IDLE.
- Value 0 and negative values (MSB=1) are not positive. 32'h8000_0000 is negative.
- Asserting reset mid-scan aborts immediately. All outputs return to reset values and done is not pulsed.

Optional Feature:
SKIP_NONPOSITIVE_EN
- Defined: in SCAN, entries <= 0 are not offered. Each one costs one cycle with out_valid=0, and idx advances unconditionally. Only positive entries appear on the interface. If the last entry is non-positive, its skip cycle leads directly to DONE. An all-non-positive bank produces no transfers, only done after N_UNITS skip cycles.
- Undefined: every entry is offered in index order, as specified above.

Test Plan:
- Reset mid-scan: start, accept 2 entries, assert reset -> out_valid=0, busy=0, done never pulses, positive_count=0; the next start rescans from index 0.
- Bank {0,5,0,0}, out_ready=1 -> 4 transfers (idx 0..3, data 0,5,0,0) on consecutive cycles starting 1 cycle after start; done 1 cycle later; positive_count=1, winner_found=1, winner_index=1.
- Bank {3,7,-2,0} with out_ready toggling 1,0,1,0... -> data held stable while ready=0; positive_count=2, winner_found=0, winner_index=0.
- Snapshot/ignore: change reg_values and pulse start during SCAN -> streamed values are the original snapshot, and no second scan occurs.
- Bank {32'h8000_0000,0,0,1} -> positive_count=1, winner_index=3; the negative MSB value is not counted.
- With SKIP_NONPOSITIVE_EN, bank {0,-1,9,0} -> exactly one transfer (idx 2, data 9); done 5 cycles after start with out_ready=1.
